clock_divider_multi: RTL and testbench

- Multi-channel, run-time programmable clock/tick generator. Successor to the fixed-ratio single-output divider.
- Each channel divides i_clk by a programmable period and produces a divided clock with a programmable high time, plus a one-cycle period tick.
- Divisor changes are glitch-free: they are applied only at a period boundary.
- Sits beside the control FSMs and supplies slow enables and clocks (for example display scan and 1 Hz timebase) from a single system clock.

---
 rtl/clock_divider_multi.sv | 141 ++++++++++++++
 tb/tb_clock_divider_multi.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_multi.sv
// -----------------------------------------------------------------------------
// clock_divider_multi
//   Multi-channel, run-time programmable clock/tick generator. Each channel
//   divides i_clk by a programmable period, drives a divided clock with a
//   programmable high time and a one-cycle tick at every period start.
//   New divisors are held in a shadow and only take effect at a period
//   boundary (sync, wrap or while disabled), so a write never produces a
//   truncated or stretched period.
//
// Ports
//   i_clk      system clock
//   rst        asynchronous reset, active low
//   i_en       per-channel run enable
//   i_sync     one-cycle pulse, restarts all enabled channels phase-aligned
//   i_wr       configuration write strobe
//   i_wr_ch    target channel of the write (out-of-range writes are ignored)
//   i_wr_div   new period in i_clk cycles (values below 2 are stored as 2)
//   i_wr_high  new high-phase length in i_clk cycles
//   o_clk      divided clocks (registered)
//   o_tick     one-cycle pulse at each period start (registered)
//   o_pending  shadow configuration written but not yet applied
// -----------------------------------------------------------------------------
module clock_divider_multi #(
  parameter int                NUM_CH      = 4,
  parameter int                DIV_W       = 16,
  parameter int                DEFAULT_DIV = 100,
  parameter logic [NUM_CH-1:0] REV_MASK    = '0,
  localparam int               CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] i_en,
  input  logic              i_sync,
  input  logic              i_wr,
  input  logic [CH_W-1:0]   i_wr_ch,
  input  logic [DIV_W-1:0]  i_wr_div,
  input  logic [DIV_W-1:0]  i_wr_high,
  output logic [NUM_CH-1:0] o_clk,
  output logic [NUM_CH-1:0] o_tick,
  output logic [NUM_CH-1:0] o_pending
);

  localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DEF_HIGH = DIV_W'(DEFAULT_DIV / 2);

  // Output level for counter value c: active while c < high, inverted on
  // channels whose idle level is 1.
  function automatic logic lvl(input logic [DIV_W-1:0] c,
                               input logic [DIV_W-1:0] high,
                               input logic             rev);
    return (c < high) ^ rev;
  endfunction

  logic [DIV_W-1:0]  cnt_q      [NUM_CH];
  logic [DIV_W-1:0]  cnt_d      [NUM_CH];
  logic [DIV_W-1:0]  div_act_q  [NUM_CH];
  logic [DIV_W-1:0]  div_act_d  [NUM_CH];
  logic [DIV_W-1:0]  high_act_q [NUM_CH];
  logic [DIV_W-1:0]  high_act_d [NUM_CH];
  logic [DIV_W-1:0]  div_sh_q   [NUM_CH];
  logic [DIV_W-1:0]  div_sh_d   [NUM_CH];
  logic [DIV_W-1:0]  high_sh_q  [NUM_CH];
  logic [DIV_W-1:0]  high_sh_d  [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;

  // Shadow as it will be after this edge: a same-cycle write already counts,
  // which is how a write coinciding with an apply takes effect immediately.
  logic [DIV_W-1:0]  div_new  [NUM_CH];
  logic [DIV_W-1:0]  high_new [NUM_CH];
  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] wrap;
  logic [DIV_W-1:0]  wr_div_c;

  always_comb begin
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    wr_div_c = (i_wr_div < DIV_W'(2)) ? DIV_W'(2) : i_wr_div;
    for (int k = 0; k < NUM_CH; k++) begin
      // i_wr_ch >= NUM_CH matches no channel, so such writes are dropped.
      wr_hit[k]     = i_wr && (32'(i_wr_ch) == k);
      div_new[k]    = wr_hit[k] ? wr_div_c  : div_sh_q[k];
      high_new[k]   = wr_hit[k] ? i_wr_high : high_sh_q[k];
      wrap[k]       = (cnt_q[k] == div_act_q[k] - DIV_W'(1));

      cnt_d[k]      = cnt_q[k] + DIV_W'(1);
      div_act_d[k]  = div_act_q[k];
      high_act_d[k] = high_act_q[k];
      div_sh_d[k]   = div_new[k];
      high_sh_d[k]  = high_new[k];
      pend_d[k]     = pend_q[k] | wr_hit[k];
      clk_d[k]      = lvl(cnt_q[k] + DIV_W'(1), high_act_q[k], REV_MASK[k]);
      tick_d[k]     = 1'b0;

      // Period boundary: disabled, sync or wrap. The active configuration
      // only ever changes here, with the counter going back to 0.
      if (!i_en[k] || i_sync || wrap[k]) begin
        cnt_d[k]      = '0;
        div_act_d[k]  = div_new[k];
        high_act_d[k] = high_new[k];
        pend_d[k]     = 1'b0;
        clk_d[k]      = i_en[k] ? lvl('0, high_new[k], REV_MASK[k]) : REV_MASK[k];
        // Sync restarts the phase without a tick; only a natural wrap ticks.
        tick_d[k]     = i_en[k] && !i_sync && wrap[k];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge rst) begin
    if (!rst) begin
      // NOTE: shadows are ordinary flops (not RAM), so they reset with the rest of the state.
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_q[k]      <= '0;
        div_act_q[k]  <= DEF_DIV;
        high_act_q[k] <= DEF_HIGH;
        div_sh_q[k]   <= DEF_DIV;
        high_sh_q[k]  <= DEF_HIGH;
      end
      pend_q <= '0;
      clk_q  <= REV_MASK;
      tick_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_q[k]      <= cnt_d[k];
        div_act_q[k]  <= div_act_d[k];
        high_act_q[k] <= high_act_d[k];
        div_sh_q[k]   <= div_sh_d[k];
        high_sh_q[k]  <= high_sh_d[k];
      end
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign o_clk     = clk_q;
  assign o_tick    = tick_q;
  assign o_pending = pend_q;

endmodule

// File: tb/tb_clock_divider_multi.sv
// -----------------------------------------------------------------------------
// tb_clock_divider_multi
//   Self-checking bench for clock_divider_multi (4 channels, 16-bit, default
//   period 100, channel 1 inverted). A behavioural model tracks each channel's
//   position in its period and its active/shadow configuration; directed
//   scenarios also measure periods and high times against fixed numbers.
// -----------------------------------------------------------------------------
module tb_clock_divider_multi;

  localparam int         NCH  = 4;
  localparam int         DW   = 16;
  localparam int         DDIV = 100;
  localparam logic [3:0] REV  = 4'b0010;

  logic          i_clk = 1'b0;
  logic          rst;
  logic [NCH-1:0] i_en;
  logic          i_sync;
  logic          i_wr;
  logic [1:0]    i_wr_ch;
  logic [DW-1:0] i_wr_div;
  logic [DW-1:0] i_wr_high;
  logic [NCH-1:0] o_clk;
  logic [NCH-1:0] o_tick;
  logic [NCH-1:0] o_pending;

  int checks = 0;
  int errors = 0;

  clock_divider_multi #(
    .NUM_CH(NCH), .DIV_W(DW), .DEFAULT_DIV(DDIV), .REV_MASK(REV)
  ) dut (
    .i_clk(i_clk), .rst(rst), .i_en(i_en), .i_sync(i_sync), .i_wr(i_wr),
    .i_wr_ch(i_wr_ch), .i_wr_div(i_wr_div), .i_wr_high(i_wr_high),
    .o_clk(o_clk), .o_tick(o_tick), .o_pending(o_pending)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- reference model ----------------
  int m_pos  [NCH];   // position within the current period
  int m_per  [NCH];   // active period
  int m_hi   [NCH];   // active high time
  int m_sper [NCH];   // shadow period
  int m_shi  [NCH];   // shadow high time
  bit m_pend [NCH];
  bit m_clk  [NCH];
  bit m_tick [NCH];

  function automatic bit level(int pos, int hi, int ch);
    return ((pos < hi) ? 1'b1 : 1'b0) ^ REV[ch];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_pos[k] = 0;  m_per[k] = DDIV; m_hi[k] = DDIV / 2;
      m_sper[k] = DDIV; m_shi[k] = DDIV / 2;
      m_pend[k] = 0; m_clk[k] = REV[k]; m_tick[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < NCH; k++) begin
      bit boundary;
      if (i_wr && int'(i_wr_ch) == k) begin
        m_sper[k] = (int'(i_wr_div) < 2) ? 2 : int'(i_wr_div);
        m_shi[k]  = int'(i_wr_high);
        m_pend[k] = 1;
      end
      boundary = !i_en[k] || i_sync || (m_pos[k] == m_per[k] - 1);
      m_tick[k] = i_en[k] && !i_sync && (m_pos[k] == m_per[k] - 1);
      if (boundary) begin
        m_per[k] = m_sper[k]; m_hi[k] = m_shi[k]; m_pend[k] = 0;
        m_pos[k] = 0;
      end else begin
        m_pos[k] = m_pos[k] + 1;
      end
      m_clk[k] = i_en[k] ? level(m_pos[k], m_hi[k], k) : REV[k];
    end
  endtask

  function automatic logic [NCH-1:0] e_clk();
    for (int k = 0; k < NCH; k++) e_clk[k] = m_clk[k];
  endfunction
  function automatic logic [NCH-1:0] e_tick();
    for (int k = 0; k < NCH; k++) e_tick[k] = m_tick[k];
  endfunction
  function automatic logic [NCH-1:0] e_pend();
    for (int k = 0; k < NCH; k++) e_pend[k] = m_pend[k];
  endfunction

  // One clock: model advances on the edge, outputs are stable by the negedge.
  task automatic tick();
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
  endtask

  task automatic write_cfg(int ch, int dv, int hi);
    i_wr = 1'b1; i_wr_ch = 2'(ch); i_wr_div = DW'(dv); i_wr_high = DW'(hi);
    tick();
    i_wr = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge i_clk);
    rst = 1'b0; i_en = '0; i_sync = 0; i_wr = 0;
    model_reset();
    @(negedge i_clk);
    rst = 1'b1;
  endtask

  // Runs ncyc clocks comparing everything against the model, and measures
  // period length and active-cycle count of channel ch between ticks.
  task automatic measure(int ch, int ncyc, int exp_per, int exp_hi, string name);
    int last = -1;
    int act  = 0;
    int nint = 0;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      checks++;
      if (o_clk !== e_clk() || o_tick !== e_tick() || o_pending !== e_pend()) begin
        errors++;
        $display("FAIL %s_model cyc %0d: clk/tick/pend %b/%b/%b want %b/%b/%b",
                 name, i, o_clk, o_tick, o_pending, e_clk(), e_tick(), e_pend());
      end
      if (o_tick[ch]) begin
        if (last >= 0) begin
          nint++;
          checks++;
          if (i - last != exp_per) begin
            errors++;
            $display("FAIL %s_period ch%0d: got %0d want %0d", name, ch, i - last, exp_per);
          end
          checks++;
          if (act != exp_hi) begin
            errors++;
            $display("FAIL %s_high ch%0d: got %0d want %0d", name, ch, act, exp_hi);
          end
        end
        last = i;
        act  = 0;
      end
      act += int'(o_clk[ch] ^ REV[ch]);
    end
    checks++;
    if (nint < ncyc / exp_per - 2) begin
      errors++;
      $display("FAIL %s_intervals ch%0d: got %0d want >= %0d", name, ch, nint, ncyc / exp_per - 2);
    end
  endtask

  task automatic wait_pending_clear(string name);
    int n = 0;
    while (o_pending !== '0 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (o_pending !== '0) begin
      errors++;
      $display("FAIL %s_apply_timeout: pending %b want 0000", name, o_pending);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0; i_en = '0; i_sync = 0; i_wr = 0;
    i_wr_ch = '0; i_wr_div = '0; i_wr_high = '0;
    model_reset();
    repeat (2) @(negedge i_clk);
    checks++;
    if (o_clk !== 4'b0010 || o_tick !== 4'b0000 || o_pending !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: clk/tick/pend %b/%b/%b want 0010/0000/0000",
               o_clk, o_tick, o_pending);
    end
    rst = 1'b1;
  endtask

  task automatic test_default();
    i_en = 4'hF;
    measure(0, 400, 100, 50, "default_ch0");
    measure(1, 300, 100, 50, "default_ch1");
  endtask

  task automatic test_write_apply();
    int n = 0;
    while (m_pos[1] != 30 && n < 200) begin tick(); n++; end
    write_cfg(1, 10, 3);
    checks++;
    if (o_pending[1] !== 1'b1) begin
      errors++;
      $display("FAIL wr_pending_set: got %b want 1", o_pending[1]);
    end
    n = 0;
    while (o_tick[1] !== 1'b1 && n < 120) begin
      checks++;
      if (o_pending[1] !== 1'b1) begin
        errors++;
        $display("FAIL wr_pending_hold cyc %0d: got %b want 1", n, o_pending[1]);
      end
      tick();
      n++;
    end
    checks++;
    if (n != 69 || o_pending[1] !== 1'b0) begin
      errors++;
      $display("FAIL wr_wrap: cycles %0d pend %b want 69 0", n, o_pending[1]);
    end
    measure(1, 60, 10, 3, "wr_new");
  endtask

  task automatic test_clamp();
    write_cfg(2, 1, 0);
    write_cfg(3, 8, 8);
    write_cfg(0, 8, 9);
    wait_pending_clear("clamp");
    measure(2, 40, 2, 0, "clamp_ch2");
    measure(3, 40, 8, 8, "clamp_ch3");
    measure(0, 40, 8, 8, "clamp_ch0");
  endtask

  task automatic test_rev_sync();
    i_en[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (o_clk[1] !== 1'b1 || o_tick[1] !== 1'b0) begin
        errors++;
        $display("FAIL rev_idle cyc %0d: clk %b tick %b want 1 0", i, o_clk[1], o_tick[1]);
      end
    end
    write_cfg(1, 100, 50);
    checks++;
    if (o_pending[1] !== 1'b0) begin
      errors++;
      $display("FAIL rev_disabled_write: pend %b want 0", o_pending[1]);
    end
    i_en[1] = 1'b1; i_sync = 1'b1;
    tick();
    i_sync = 1'b0;
    checks++;
    if (o_clk[1] !== 1'b0 || o_tick[1] !== 1'b0) begin
      errors++;
      $display("FAIL rev_sync_start: clk %b tick %b want 0 0", o_clk[1], o_tick[1]);
    end
    for (int j = 1; j <= 100; j++) begin
      logic ec, et;
      tick();
      et = (j == 100);
      ec = (j == 100) ? 1'b0 : (j >= 50);
      checks++;
      if (o_clk[1] !== ec || o_tick[1] !== et) begin
        errors++;
        $display("FAIL rev_first_period j=%0d: clk %b tick %b want %b %b",
                 j, o_clk[1], o_tick[1], ec, et);
      end
    end
  endtask

  task automatic test_sync_align();
    for (int k = 0; k < NCH; k++) write_cfg(k, 20, 10);
    wait_pending_clear("align");
    repeat (7) tick();
    i_sync = 1'b1;
    tick();
    i_sync = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      logic [3:0] ec, et;
      tick();
      et = (j % 20 == 0) ? 4'hF : 4'h0;
      ec = (((j % 20) < 10) ? 4'hF : 4'h0) ^ REV;
      checks++;
      if (o_clk !== ec || o_tick !== et) begin
        errors++;
        $display("FAIL align j=%0d: clk %b tick %b want %b %b", j, o_clk, o_tick, ec, et);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    apply_reset();
    i_en = 4'hF;
    repeat (10) tick();
    write_cfg(0, 30, 5);
    while (m_pos[0] != 57 && n < 200) begin tick(); n++; end
    checks++;
    if (o_pending[0] !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pending_before: got %b want 1", o_pending[0]);
    end
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (o_clk !== 4'b0010 || o_tick !== 4'b0000 || o_pending !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_async: clk/tick/pend %b/%b/%b want 0010/0000/0000",
               o_clk, o_tick, o_pending);
    end
    @(negedge i_clk);
    rst = 1'b1;
    n = 0;
    while (o_tick[0] !== 1'b1 && n < 150) begin tick(); n++; end
    checks++;
    if (n != 100) begin
      errors++;
      $display("FAIL rstmid_first_tick: edges %0d want 100", n);
    end
    measure(0, 250, 100, 50, "rstmid");
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NCH; k++)
        if ($urandom_range(0, 63) == 0) i_en[k] = ~i_en[k];
      i_sync = ($urandom_range(0, 49) == 0);
      i_wr   = ($urandom_range(0, 7) == 0);
      i_wr_ch   = 2'($urandom_range(0, 3));
      i_wr_div  = DW'($urandom_range(0, 12));
      i_wr_high = DW'($urandom_range(0, 14));
      tick();
      checks++;
      if (o_clk !== e_clk() || o_tick !== e_tick() || o_pending !== e_pend()) begin
        errors++;
        $display("FAIL random cyc %0d: clk/tick/pend %b/%b/%b want %b/%b/%b",
                 i, o_clk, o_tick, o_pending, e_clk(), e_tick(), e_pend());
      end
    end
    i_sync = 0; i_wr = 0;
  endtask

  initial begin
    test_reset();
    test_default();
    test_write_apply();
    test_clamp();
    test_rev_sync();
    test_sync_align();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
